// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer sharing one single-port synchronous RAM between the fetch port (read-only) and the data port (read/write).
// Tie-break on simultaneous requests: define MEM_ARB_RR_EN for round-robin; the default build gives the data port fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // RAM side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic              any_req;
  logic              pick_data;
  logic              in_issue;
  logic              in_rdata;

  assign any_req  = if_req | d_req;
  assign in_issue = (state_q == ST_ISSUE);
  assign in_rdata = (state_q == ST_RDATA);

`ifdef MEM_ARB_RR_EN
  // On a tie the port that did not win the previous access goes next.
  assign pick_data = d_req & (~if_req | (last_owner_q == OWN_FETCH));
`else
  assign pick_data = d_req;
`endif

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d      = ST_ISSUE;
          owner_d      = pick_data ? OWN_DATA : OWN_FETCH;
          last_owner_d = owner_d;
          if (pick_data) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
          end
        end
      end
      ST_ISSUE: state_d = we_q ? ST_IDLE : ST_RDATA;
      ST_RDATA: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples values from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_FETCH;
      last_owner_q <= OWN_FETCH;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Read return: capture during RDATA, present data with a one-cycle valid pulse next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= in_rdata && (owner_q == OWN_FETCH);
      d_rvalid_q  <= in_rdata && (owner_q == OWN_DATA);
      if (in_rdata) begin
        if (owner_q == OWN_FETCH) begin
          if_rdata_q <= mem_rdata;
        end else begin
          d_rdata_q  <= mem_rdata;
        end
      end
    end
  end

  // Everything below decodes registered state only; no request input reaches an output combinationally.
  assign if_gnt    = in_issue && (owner_q == OWN_FETCH);
  assign d_gnt     = in_issue && (owner_q == OWN_DATA);
  assign mem_en    = in_issue;
  assign mem_we    = in_issue && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

endmodule
